// File: rtl/sd_cmd_arb_pkg.sv
// SD command-register arbiter shared types.
// State codes, owner tags and default widths.
package sd_cmd_arb_pkg;

  localparam int ARG_W_DEF = 32;
  localparam int SET_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_ISSUE    = 2'd1;
  localparam state_t ST_WAIT_RSP = 2'd2;

  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/sd_cmd_arbiter.sv
// Two-way round-robin owner of the SD command-register write port.
// Owner is held until the command engine settles idle.
module sd_cmd_arbiter
  import sd_cmd_arb_pkg::*;
#(
  parameter int ARG_W  = ARG_W_DEF,
  parameter int SET_W  = SET_W_DEF,
  parameter int TMO    = 255,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_req,
  input  logic [ARG_W-1:0] h_arg,
  input  logic [SET_W-1:0] h_set,
  output logic             h_ack,
  output logic             h_err,
  input  logic             d_req,
  input  logic [ARG_W-1:0] d_arg,
  input  logic [SET_W-1:0] d_set,
  output logic             d_ack,
  output logic             d_err,
  input  logic             cmd_busy,
  input  logic             we_ack,
  output logic             we_req,
  output logic [ARG_W-1:0] cmd_arg,
  output logic [SET_W-1:0] cmd_set,
  output logic             owner,
  output logic             arb_busy
);

  localparam int TMAX = (TMO > SETTLE) ? TMO : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0] SET_T    = TW'(SETTLE);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          last_grant;
  logic          pick;

  // Sole requester wins; on a tie the one not served last wins.
  always_comb begin
    pick = OWN_HOST;
    unique case (1'b1)
      (d_req && !h_req): pick = OWN_DATA;
      (d_req && h_req):  pick = ~last_grant;
      default:           pick = OWN_HOST;
    endcase
  end

  // Grant, write handshake with watchdog, and settle-to-idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      last_grant <= OWN_HOST;
      owner      <= OWN_HOST;
      arb_busy   <= 1'b0;
      we_req     <= 1'b0;
      cmd_arg    <= '0;
      cmd_set    <= '0;
      h_ack      <= 1'b0;
      h_err      <= 1'b0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      h_ack <= 1'b0;
      h_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if ((h_req || d_req) && !cmd_busy) begin
            owner    <= pick;
            cmd_arg  <= pick ? d_arg : h_arg;
            cmd_set  <= pick ? d_set : h_set;
            we_req   <= 1'b1;
            arb_busy <= 1'b1;
            timer    <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (we_ack) begin
            we_req <= 1'b0;
            h_ack  <= (owner == OWN_HOST);
            d_ack  <= (owner == OWN_DATA);
            timer  <= '0;
            state  <= ST_WAIT_RSP;
          end else if (timer == TMO_LAST) begin
            we_req     <= 1'b0;
            h_err      <= (owner == OWN_HOST);
            d_err      <= (owner == OWN_DATA);
            last_grant <= owner;
            arb_busy   <= 1'b0;
            timer      <= '0;
            state      <= ST_IDLE;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        ST_WAIT_RSP: begin
          if (timer != SET_T) begin
            timer <= timer + T_ONE;
          end else if (!cmd_busy) begin
            last_grant <= owner;
            arb_busy   <= 1'b0;
            timer      <= '0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          we_req   <= 1'b0;
          arb_busy <= 1'b0;
          timer    <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
